// File: rtl/mux_b_pipe.sv
// Bus-B operand select (register file or constant field) feeding
// a 2-entry valid/ready skid buffer.
module mux_b_pipe #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int CONST_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             reg_sel,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
  input  logic [CONST_W-1:0]           const_in,
  input  logic                         mb,
  input  logic                         sext,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            bus_b,
  output logic                         bus_b_src,
  output logic                         sel_err
);

  localparam int ENT_W = DATA_W + 2;
  localparam int EXT_W = DATA_W - CONST_W;
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0] NREG_L = (SEL_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [ENT_W-1:0]   head, head_d;
  logic [ENT_W-1:0]   skid, skid_d;
  logic [ENT_W-1:0]   new_ent;
  logic [DATA_W-1:0]  const_ext;
  logic [DATA_W-1:0]  op_val;
  logic               op_err;
  logic               sel_ok;
  logic               accept;
  logic               drain;
  logic [DATA_W-1:0]  regs [NSLOT];

  if (EXT_W > 0) begin : g_ext
    assign const_ext = {{EXT_W{sext & const_in[CONST_W-1]}}, const_in};
  end else begin : g_noext
    assign const_ext = const_in;
  end

  // Unpopulated index slots read as zero so reg_sel never indexes out of range
  for (genvar i = 0; i < NSLOT; i++) begin : g_regs
    if (i < NUM_REGS) begin : g_pop
      assign regs[i] = reg_data[i*DATA_W +: DATA_W];
    end else begin : g_unpop
      assign regs[i] = '0;
    end
  end

  assign sel_ok = ({1'b0, reg_sel} < NREG_L);

  always_comb begin
    op_val = '0;
    op_err = 1'b0;
    if (mb) begin
      op_val = const_ext;
    end else if (sel_ok) begin
      op_val = regs[reg_sel];
    end else begin
      op_err = 1'b1;
    end
  end

  assign new_ent   = {op_val, mb, op_err};
  assign in_ready  = rst_n & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state;
    head_d  = head;
    skid_d  = skid;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = new_ent;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d = TWO;
          skid_d  = new_ent;
        end else if (accept) begin
          head_d = new_ent;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d = ONE;
          head_d  = skid;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_d;
      head  <= head_d;
      skid  <= skid_d;
    end
  end

  assign {bus_b, bus_b_src, sel_err} = head;

endmodule

// File: tb/tb_mux_b_pipe.sv
// Bench for mux_b_pipe: directed literal checks plus randomized
// traffic against a queue model, on NUM_REGS=8 and NUM_REGS=6 instances.
module tb_mux_b_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  reg_sel;
  logic [63:0] reg_data;
  logic [2:0]  const_in;
  logic        mb;
  logic        sext;

  logic        in_ready8, out_valid8, src8, err8;
  logic [7:0]  bus8;
  logic        in_ready6, out_valid6, src6, err6;
  logic [7:0]  bus6;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] v;
    logic       s;
    logic       e;
  } ent_t;

  ent_t q8[$];
  ent_t q6[$];

  always #5 clk = ~clk;

  mux_b_pipe #(.DATA_W(8), .NUM_REGS(8), .SEL_W(3), .CONST_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .reg_sel(reg_sel), .reg_data(reg_data), .const_in(const_in),
    .mb(mb), .sext(sext), .out_valid(out_valid8), .out_ready(out_ready),
    .bus_b(bus8), .bus_b_src(src8), .sel_err(err8)
  );

  mux_b_pipe #(.DATA_W(8), .NUM_REGS(6), .SEL_W(3), .CONST_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .reg_sel(reg_sel), .reg_data(reg_data[47:0]), .const_in(const_in),
    .mb(mb), .sext(sext), .out_valid(out_valid6), .out_ready(out_ready),
    .bus_b(bus6), .bus_b_src(src6), .sel_err(err6)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand as an integer: constant with optional two's-complement
  // interpretation of a 3-bit field, or register lookup with range check.
  function automatic ent_t model_op(input int nregs);
    ent_t r;
    int   v;
    r.s = mb;
    r.e = 1'b0;
    if (mb) begin
      v = int'(const_in);
      if (sext && v >= 4) v = v - 8;
      r.v = 8'(v & 255);
    end else if (int'(reg_sel) < nregs) begin
      r.v = reg_data[int'(reg_sel)*8 +: 8];
    end else begin
      r.v = 8'h00;
      r.e = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q6.delete();
    end else begin
      bit acc, drn;
      ent_t n8, n6;
      acc = in_valid && (q8.size() < 2);
      drn = out_ready && (q8.size() > 0);
      n8 = model_op(8);
      n6 = model_op(6);
      if (drn) begin
        void'(q8.pop_front());
        void'(q6.pop_front());
      end
      if (acc) begin
        q8.push_back(n8);
        q6.push_back(n6);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      check("in_ready8", in_ready8, rst_n && q8.size() < 2);
      check("out_valid8", out_valid8, q8.size() > 0);
      check("in_ready6", in_ready6, rst_n && q6.size() < 2);
      check("out_valid6", out_valid6, q6.size() > 0);
      if (q8.size() > 0) begin
        check("bus_b8", bus8, q8[0].v);
        check("src8", src8, q8[0].s);
        check("err8", err8, q8[0].e);
      end
      if (q6.size() > 0) begin
        check("bus_b6", bus6, q6[0].v);
        check("src6", src6, q6[0].s);
        check("err6", err6, q6[0].e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reg_sel   = 3'd0;
    reg_data  = 64'h7766_5544_3322_1100;
    const_in  = 3'd0;
    mb        = 1'b0;
    sext      = 1'b0;

    // reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", out_valid8, 1'b0);
      check("rst_bus_b", bus8, 8'h00);
      check("rst_in_ready", in_ready8, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("rel_in_ready", in_ready8, 1'b1);

    // register path
    reg_data[15:8] = 8'h5A;
    reg_sel  = 3'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("reg_valid", out_valid8, 1'b1);
    check("reg_bus_b", bus8, 8'h5A);
    check("reg_src", src8, 1'b0);
    check("reg_err", err8, 1'b0);
    step();

    // constant path
    mb = 1'b1; const_in = 3'b101; sext = 1'b0; in_valid = 1'b1;
    step();
    check("const_zext", bus8, 8'h05);
    check("const_src", src8, 1'b1);
    sext = 1'b1;
    step();
    check("const_sext_neg", bus8, 8'hFD);
    const_in = 3'b011;
    step();
    check("const_sext_pos", bus8, 8'h03);
    in_valid = 1'b0;
    step();

    // backpressure: A, B fill the buffer, C waits
    mb = 1'b0; reg_sel = 3'd0; out_ready = 1'b0;
    reg_data[7:0] = 8'h11; in_valid = 1'b1;
    step();
    reg_data[7:0] = 8'h22;
    step();
    check("bp_full", in_ready8, 1'b0);
    reg_data[7:0] = 8'h33;
    step();
    check("bp_held_ready", in_ready8, 1'b0);
    check("bp_head_a", bus8, 8'h11);
    out_ready = 1'b1;
    step();
    check("bp_head_b", bus8, 8'h22);
    step();
    in_valid = 1'b0;
    check("bp_head_c", bus8, 8'h33);
    step();
    check("bp_empty", out_valid8, 1'b0);

    // streaming constants 0..7
    mb = 1'b1; sext = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      const_in = 3'(i);
      step();
      check("stream_valid", out_valid8, 1'b1);
      check("stream_val", bus8, 8'(i));
    end
    in_valid = 1'b0;
    step();

    // reset with two entries held
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    step();
    check("two_held", out_valid8, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("midrst_valid", out_valid8, 1'b0);
    check("midrst_bus_b", bus8, 8'h00);
    rst_n = 1'b1; out_ready = 1'b1;
    step();

    // out-of-range select on the 6-register instance
    reg_data[63:56] = 8'hC3;
    mb = 1'b0; reg_sel = 3'd7; in_valid = 1'b1;
    step();
    check("oor6_bus_b", bus6, 8'h00);
    check("oor6_err", err6, 1'b1);
    check("inr8_bus_b", bus8, 8'hC3);
    check("inr8_err", err8, 1'b0);
    mb = 1'b1; const_in = 3'd6; sext = 1'b1;
    step();
    check("const6_err", err6, 1'b0);
    check("const6_bus_b", bus6, 8'hFE);
    in_valid = 1'b0;
    step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reg_sel   = 3'($urandom_range(0, 7));
      reg_data  = {$urandom, $urandom};
      const_in  = 3'($urandom_range(0, 7));
      mb        = 1'($urandom_range(0, 1));
      sext      = 1'($urandom_range(0, 1));
      step();
    end

    in_valid = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
